// File: rtl/nios_debug_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the JTAG debug command path and the CPU debug data master.
// Optional macro OCIMEM_CPU_WPROT_EN: blocks CPU writes to the top quarter of the RAM (debug vector/monitor area).
module nios_debug_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  // JTAG debug slave command path
  input  logic                jtag_cmd_valid,
  input  logic                jtag_cmd_write,
  input  logic [ADDR_W-1:0]   jtag_cmd_addr,
  input  logic [DATA_W-1:0]   jtag_cmd_data,
  output logic                jtag_busy,
  output logic [DATA_W-1:0]   MonDReg,
  output logic                monitor_ready,
  output logic                monitor_error,
  // CPU debug data master (Avalon-MM slave side)
  input  logic [ADDR_W-1:0]   cpu_address,
  input  logic                cpu_read,
  input  logic                cpu_write,
  input  logic [DATA_W-1:0]   cpu_writedata,
  input  logic [DATA_W/8-1:0] cpu_byteenable,
  output logic [DATA_W-1:0]   cpu_readdata,
  output logic                cpu_waitrequest,
  // OCI RAM port
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_we,
  output logic [DATA_W/8-1:0] ram_be,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RDATA  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // JTAG pending command register
  logic                jpend_q;
  logic                jwrite_q;
  logic [ADDR_W-1:0]   jaddr_q;
  logic [DATA_W-1:0]   jdata_q;

  // Granted transaction, drives the RAM port
  logic                t_jtag_q;
  logic                t_we_q;
  logic                t_wprot_q;
  logic [ADDR_W-1:0]   t_addr_q;
  logic [DATA_W/8-1:0] t_be_q;
  logic [DATA_W-1:0]   t_wdata_q;

  logic                last_jtag_q;
  logic                monitor_ready_q;
  logic                monitor_error_q;
  logic [DATA_W-1:0]   mon_data_q;
  logic [DATA_W-1:0]   cpu_rdata_q;

  logic                cpu_req;
  logic                jtag_accept;
  logic                grant_jtag;
  logic                grant_any;
  logic                cpu_wprot;

  // FSM outputs
  logic                ram_we_c;
  logic                cpu_done;
  logic                jtag_fin;
  logic                mon_load;
  logic                cpu_rd_phase;

  assign cpu_req     = cpu_read | cpu_write;
  assign jtag_accept = jtag_cmd_valid & ~jpend_q;

  // On a conflict the requester that was not served last wins.
  assign grant_jtag = jpend_q & (~cpu_req | ~last_jtag_q);
  assign grant_any  = jpend_q | cpu_req;

`ifdef OCIMEM_CPU_WPROT_EN
  assign cpu_wprot = cpu_write & (cpu_address[ADDR_W-1 -: 2] == 2'b11);
`else
  assign cpu_wprot = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (grant_any) state_d = S_ACCESS;
      S_ACCESS: state_d = t_we_q ? S_IDLE : S_RDATA;
      S_RDATA:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ram_we_c     = 1'b0;
    cpu_done     = 1'b0;
    jtag_fin     = 1'b0;
    mon_load     = 1'b0;
    cpu_rd_phase = 1'b0;
    case (state_q)
      S_ACCESS: begin
        ram_we_c = t_we_q & ~t_wprot_q;
        if (t_we_q) begin
          jtag_fin = t_jtag_q;
          cpu_done = ~t_jtag_q;
        end
      end
      S_RDATA: begin
        jtag_fin     = t_jtag_q;
        mon_load     = t_jtag_q;
        cpu_done     = ~t_jtag_q;
        cpu_rd_phase = ~t_jtag_q;
      end
      default: ;
    endcase
  end

  // JTAG pending command and monitor status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jpend_q         <= 1'b0;
      jwrite_q        <= 1'b0;
      jaddr_q         <= '0;
      jdata_q         <= '0;
      monitor_ready_q <= 1'b0;
      monitor_error_q <= 1'b0;
      mon_data_q      <= '0;
    end else begin
      if (jtag_fin) begin
        jpend_q <= 1'b0;
      end else if (jtag_accept) begin
        jpend_q  <= 1'b1;
        jwrite_q <= jtag_cmd_write;
        jaddr_q  <= jtag_cmd_addr;
        jdata_q  <= jtag_cmd_data;
      end
      if (jtag_cmd_valid && jpend_q) begin
        monitor_error_q <= 1'b1;
      end
      if (jtag_accept) begin
        monitor_ready_q <= 1'b0;
      end else if (mon_load) begin
        monitor_ready_q <= 1'b1;
      end
      if (mon_load) begin
        mon_data_q <= ram_rdata;
      end
    end
  end

  // Grant capture: the winner's request is frozen for the whole access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_jtag_q    <= 1'b0;
      t_we_q      <= 1'b0;
      t_wprot_q   <= 1'b0;
      t_addr_q    <= '0;
      t_be_q      <= '0;
      t_wdata_q   <= '0;
      last_jtag_q <= 1'b0;
    end else if (state_q == S_IDLE && grant_any) begin
      last_jtag_q <= grant_jtag;
      t_jtag_q    <= grant_jtag;
      if (grant_jtag) begin
        t_we_q    <= jwrite_q;
        t_wprot_q <= 1'b0;
        t_addr_q  <= jaddr_q;
        t_be_q    <= '1;
        t_wdata_q <= jdata_q;
      end else begin
        t_we_q    <= cpu_write;
        t_wprot_q <= cpu_wprot;
        t_addr_q  <= cpu_address;
        t_be_q    <= cpu_byteenable;
        t_wdata_q <= cpu_writedata;
      end
    end
  end

  // Hold the last CPU read word so cpu_readdata is stable outside RDATA.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rdata_q <= '0;
    end else if (cpu_rd_phase) begin
      cpu_rdata_q <= ram_rdata;
    end
  end

  assign cpu_readdata    = cpu_rd_phase ? ram_rdata : cpu_rdata_q;
  assign cpu_waitrequest = cpu_req & ~cpu_done;

  assign jtag_busy     = jpend_q;
  assign MonDReg       = mon_data_q;
  assign monitor_ready = monitor_ready_q;
  assign monitor_error = monitor_error_q;

  assign ram_addr  = t_addr_q;
  assign ram_be    = t_be_q;
  assign ram_wdata = t_wdata_q;
  assign ram_we    = ram_we_c;

endmodule

// File: tb/tb_nios_debug_ocimem_arbiter.sv
// Self-checking bench for nios_debug_ocimem_arbiter with a behavioural 256x32 RAM and read scoreboards.
// Honours OCIMEM_CPU_WPROT_EN in its expectations.
module tb_nios_debug_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        jtag_cmd_valid = 1'b0;
  logic        jtag_cmd_write = 1'b0;
  logic [7:0]  jtag_cmd_addr = '0;
  logic [31:0] jtag_cmd_data = '0;
  logic        jtag_busy;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;
  logic [7:0]  cpu_address = '0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [31:0] cpu_writedata = '0;
  logic [3:0]  cpu_byteenable = '0;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:255];
  logic [31:0] exp_mem [0:255];
  logic        mem_loaded = 1'b0;
  logic [31:0] cpu_q [$];
  logic [31:0] jtag_q [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  nios_debug_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .jtag_cmd_valid(jtag_cmd_valid), .jtag_cmd_write(jtag_cmd_write),
    .jtag_cmd_addr(jtag_cmd_addr), .jtag_cmd_data(jtag_cmd_data),
    .jtag_busy(jtag_busy), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {8'hA0 ^ b, b, ~b, 8'h3C};
  endfunction

  // Synchronous-read RAM model with byte enables
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end
    end
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be, input logic exp_we);
    @(posedge clk); #1;
    cpu_write = 1'b1; cpu_address = a; cpu_writedata = d; cpu_byteenable = be;
    @(negedge clk);
    checks++; if (cpu_waitrequest !== 1'b1) begin errors++; $display("FAIL cpu_wr_wait_c0 got %b exp 1", cpu_waitrequest); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL cpu_wr_we_c0 got %b exp 0", ram_we); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL cpu_wr_wait_c1 got %b exp 0", cpu_waitrequest); end
    checks++; if (ram_we !== exp_we) begin errors++; $display("FAIL cpu_wr_we_c1 got %b exp %b", ram_we, exp_we); end
    checks++; if (ram_addr !== a) begin errors++; $display("FAIL cpu_wr_addr got %h exp %h", ram_addr, a); end
    checks++; if (ram_be !== be) begin errors++; $display("FAIL cpu_wr_be got %h exp %h", ram_be, be); end
    checks++; if (ram_wdata !== d) begin errors++; $display("FAIL cpu_wr_wdata got %h exp %h", ram_wdata, d); end
    @(posedge clk); #1;
    cpu_write = 1'b0;
    @(negedge clk);
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL cpu_wr_we_c2 got %b exp 0", ram_we); end
    if (exp_we) begin
      for (int b = 0; b < 4; b++) if (be[b]) exp_mem[a][8*b +: 8] = d[8*b +: 8];
    end
    $display("txn cpu_wr addr=%h data=%h be=%h", a, d, be);
  endtask

  task automatic cpu_rd(input logic [7:0] a);
    logic [31:0] e;
    @(posedge clk); #1;
    cpu_read = 1'b1; cpu_address = a;
    cpu_q.push_back(exp_mem[a]);
    @(negedge clk);
    checks++; if (cpu_waitrequest !== 1'b1) begin errors++; $display("FAIL cpu_rd_wait_c0 got %b exp 1", cpu_waitrequest); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (cpu_waitrequest !== 1'b1) begin errors++; $display("FAIL cpu_rd_wait_c1 got %b exp 1", cpu_waitrequest); end
    checks++; if (ram_addr !== a) begin errors++; $display("FAIL cpu_rd_addr got %h exp %h", ram_addr, a); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL cpu_rd_wait_c2 got %b exp 0", cpu_waitrequest); end
    e = cpu_q.pop_front();
    checks++; if (cpu_readdata !== e) begin errors++; $display("FAIL cpu_rd_data addr=%h got %h exp %h", a, cpu_readdata, e); end
    $display("txn cpu_rd addr=%h data=%h", a, cpu_readdata);
    @(posedge clk); #1;
    cpu_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic jtag_rd(input logic [7:0] a);
    logic [31:0] e;
    @(posedge clk); #1;
    jtag_cmd_valid = 1'b1; jtag_cmd_write = 1'b0; jtag_cmd_addr = a;
    jtag_q.push_back(exp_mem[a]);
    @(negedge clk);
    checks++; if (jtag_busy !== 1'b0) begin errors++; $display("FAIL jtag_rd_busy_c0 got %b exp 0", jtag_busy); end
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      jtag_cmd_valid = 1'b0;
      @(negedge clk);
      checks++; if (jtag_busy !== 1'b1) begin errors++; $display("FAIL jtag_rd_busy_c%0d got %b exp 1", c, jtag_busy); end
      checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL jtag_rd_ready_c%0d got %b exp 0", c, monitor_ready); end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (monitor_ready !== 1'b1) begin errors++; $display("FAIL jtag_rd_ready_c4 got %b exp 1", monitor_ready); end
    checks++; if (jtag_busy !== 1'b0) begin errors++; $display("FAIL jtag_rd_busy_c4 got %b exp 0", jtag_busy); end
    e = jtag_q.pop_front();
    checks++; if (MonDReg !== e) begin errors++; $display("FAIL jtag_rd_data addr=%h got %h exp %h", a, MonDReg, e); end
    $display("txn jtag_rd addr=%h data=%h", a, MonDReg);
  endtask

  task automatic jtag_wr(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    jtag_cmd_valid = 1'b1; jtag_cmd_write = 1'b1; jtag_cmd_addr = a; jtag_cmd_data = d;
    @(negedge clk);
    @(posedge clk); #1;
    jtag_cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (jtag_busy !== 1'b1) begin errors++; $display("FAIL jtag_wr_busy_c1 got %b exp 1", jtag_busy); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL jtag_wr_we_c1 got %b exp 0", ram_we); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL jtag_wr_we_c2 got %b exp 1", ram_we); end
    checks++; if (ram_addr !== a) begin errors++; $display("FAIL jtag_wr_addr got %h exp %h", ram_addr, a); end
    checks++; if (ram_wdata !== d) begin errors++; $display("FAIL jtag_wr_wdata got %h exp %h", ram_wdata, d); end
    checks++; if (ram_be !== 4'hF) begin errors++; $display("FAIL jtag_wr_be got %h exp f", ram_be); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (jtag_busy !== 1'b0) begin errors++; $display("FAIL jtag_wr_busy_c3 got %b exp 0", jtag_busy); end
    exp_mem[a] = d;
    $display("txn jtag_wr addr=%h data=%h", a, d);
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", ram_we); end
    checks++; if (jtag_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", jtag_busy); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL rst_mondreg got %h exp 0", MonDReg); end
    checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", monitor_ready); end
    checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL rst_error got %b exp 0", monitor_error); end
    checks++; if (cpu_readdata !== 32'h0) begin errors++; $display("FAIL rst_readdata got %h exp 0", cpu_readdata); end
    checks++; if (ram_addr !== 8'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", ram_addr); end
    checks++; if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL rst_wait got %b exp 0", cpu_waitrequest); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_we_idle got %b exp 0", ram_we); end
    $display("txn reset done");
  endtask

  task automatic test_cpu_write();
    cpu_wr(8'h10, 32'hDEADBEEF, 4'hF, 1'b1);
  endtask

  task automatic test_cpu_read();
    cpu_rd(8'h10);
  endtask

  task automatic test_jtag_read();
    jtag_rd(8'h10);
  endtask

  task automatic test_jtag_write();
    jtag_wr(8'h20, 32'hCAFEF00D);
    cpu_rd(8'h20);
  endtask

  task automatic test_byteenable();
    cpu_wr(8'h40, 32'hAABBCCDD, 4'b0101, 1'b1);
    cpu_rd(8'h40);
  endtask

  task automatic test_contention();
    logic [7:0]  addrs [0:5];
    logic [31:0] e;
    int k, cyc, j_start, j_done, cpu_between;
    bit prev_ready, done_now;
    addrs[0] = 8'h10; addrs[1] = 8'h20; addrs[2] = 8'h40;
    addrs[3] = 8'h05; addrs[4] = 8'h10; addrs[5] = 8'h20;
    k = 0; cyc = 0; j_start = -1; j_done = -1; cpu_between = 0;
    @(posedge clk); #1;
    cpu_read = 1'b1; cpu_address = addrs[0];
    cpu_q.push_back(exp_mem[addrs[0]]);
    prev_ready = monitor_ready;
    while ((k < 6 || j_done < 0) && cyc < 60) begin
      if (cyc == 3) begin
        jtag_cmd_valid = 1'b1; jtag_cmd_write = 1'b0; jtag_cmd_addr = 8'h40;
        jtag_q.push_back(exp_mem[8'h40]);
        j_start = cyc;
      end
      @(negedge clk);
      done_now = cpu_read && !cpu_waitrequest;
      if (done_now) begin
        checks++;
        if (cpu_q.size() == 0) begin
          errors++; $display("FAIL cont_cpu_extra got completion exp none");
        end else begin
          e = cpu_q.pop_front();
          if (cpu_readdata !== e) begin errors++; $display("FAIL cont_cpu_data got %h exp %h", cpu_readdata, e); end
        end
        $display("txn cpu_rd addr=%h data=%h cycle=%0d", cpu_address, cpu_readdata, cyc);
        k++;
        if (j_start >= 0 && j_done < 0) cpu_between++;
      end
      if (monitor_ready && !prev_ready) begin
        checks++;
        if (jtag_q.size() == 0) begin
          errors++; $display("FAIL cont_jtag_extra got completion exp none");
        end else begin
          e = jtag_q.pop_front();
          if (MonDReg !== e) begin errors++; $display("FAIL cont_jtag_data got %h exp %h", MonDReg, e); end
        end
        $display("txn jtag_rd addr=40 data=%h cycle=%0d", MonDReg, cyc);
        j_done = cyc;
      end
      prev_ready = monitor_ready;
      @(posedge clk); #1;
      cyc++;
      jtag_cmd_valid = 1'b0;
      if (done_now) begin
        if (k < 6) begin
          cpu_address = addrs[k];
          cpu_q.push_back(exp_mem[addrs[k]]);
        end else begin
          cpu_read = 1'b0;
        end
      end
    end
    cpu_read = 1'b0;
    checks++; if (k != 6) begin errors++; $display("FAIL cont_cpu_count got %0d exp 6", k); end
    checks++; if (j_done < 0 || (j_done - j_start) > 7) begin errors++; $display("FAIL cont_jtag_latency got %0d exp <=7", j_done - j_start); end
    checks++; if (cpu_between != 1) begin errors++; $display("FAIL cont_cpu_between got %0d exp 1", cpu_between); end
    @(negedge clk);
  endtask

  task automatic test_same_cycle();
    logic [31:0] e;
    @(posedge clk); #1;
    cpu_read = 1'b1; cpu_address = 8'h20;
    jtag_cmd_valid = 1'b1; jtag_cmd_write = 1'b0; jtag_cmd_addr = 8'h10;
    cpu_q.push_back(exp_mem[8'h20]);
    jtag_q.push_back(exp_mem[8'h10]);
    @(negedge clk);
    checks++; if (cpu_waitrequest !== 1'b1) begin errors++; $display("FAIL same_wait_c0 got %b exp 1", cpu_waitrequest); end
    @(posedge clk); #1;
    jtag_cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (jtag_busy !== 1'b1) begin errors++; $display("FAIL same_busy_c1 got %b exp 1", jtag_busy); end
    checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL same_ready_c1 got %b exp 0", monitor_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL same_wait_c2 got %b exp 0", cpu_waitrequest); end
    e = cpu_q.pop_front();
    checks++; if (cpu_readdata !== e) begin errors++; $display("FAIL same_cpu_data got %h exp %h", cpu_readdata, e); end
    $display("txn cpu_rd addr=20 data=%h", cpu_readdata);
    @(posedge clk); #1;
    cpu_read = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (ram_addr !== 8'h10) begin errors++; $display("FAIL same_jtag_addr_c4 got %h exp 10", ram_addr); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL same_ready_c5 got %b exp 0", monitor_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (monitor_ready !== 1'b1) begin errors++; $display("FAIL same_ready_c6 got %b exp 1", monitor_ready); end
    checks++; if (jtag_busy !== 1'b0) begin errors++; $display("FAIL same_busy_c6 got %b exp 0", jtag_busy); end
    e = jtag_q.pop_front();
    checks++; if (MonDReg !== e) begin errors++; $display("FAIL same_jtag_data got %h exp %h", MonDReg, e); end
    $display("txn jtag_rd addr=10 data=%h", MonDReg);
  endtask

  task automatic test_overrun_reset();
    @(posedge clk); #1;
    jtag_cmd_valid = 1'b1; jtag_cmd_write = 1'b1; jtag_cmd_addr = 8'h30; jtag_cmd_data = 32'h11112222;
    @(negedge clk);
    checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL ovr_err_c0 got %b exp 0", monitor_error); end
    @(posedge clk); #1;
    jtag_cmd_data = 32'h33334444;
    @(negedge clk);
    checks++; if (jtag_busy !== 1'b1) begin errors++; $display("FAIL ovr_busy_c1 got %b exp 1", jtag_busy); end
    @(posedge clk); #1;
    jtag_cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (monitor_error !== 1'b1) begin errors++; $display("FAIL ovr_err_c2 got %b exp 1", monitor_error); end
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL ovr_we_c2 got %b exp 1", ram_we); end
    checks++; if (ram_wdata !== 32'h11112222) begin errors++; $display("FAIL ovr_wdata got %h exp 11112222", ram_wdata); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (jtag_busy !== 1'b0) begin errors++; $display("FAIL ovr_busy_c3 got %b exp 0", jtag_busy); end
    exp_mem[8'h30] = 32'h11112222;
    $display("txn jtag_wr addr=30 data=11112222 (second strobe dropped)");
    jtag_rd(8'h30);
    checks++; if (monitor_error !== 1'b1) begin errors++; $display("FAIL ovr_err_sticky got %b exp 1", monitor_error); end
    // reset asserted while the next JTAG read sits in RDATA
    @(posedge clk); #1;
    jtag_cmd_valid = 1'b1; jtag_cmd_write = 1'b0; jtag_cmd_addr = 8'h10;
    @(posedge clk); #1;
    jtag_cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (jtag_busy !== 1'b1) begin errors++; $display("FAIL mrst_busy_before got %b exp 1", jtag_busy); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL mrst_mondreg got %h exp 0", MonDReg); end
    checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL mrst_ready got %b exp 0", monitor_ready); end
    checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL mrst_error got %b exp 0", monitor_error); end
    checks++; if (jtag_busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got %b exp 0", jtag_busy); end
    checks++; if (ram_addr !== 8'h0) begin errors++; $display("FAIL mrst_addr got %h exp 0", ram_addr); end
    $display("txn reset mid-RDATA");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL mrst_after_mondreg got %h exp 0", MonDReg); end
  endtask

  task automatic test_wprot();
    logic exp_we;
`ifdef OCIMEM_CPU_WPROT_EN
    exp_we = 1'b0;
`else
    exp_we = 1'b1;
`endif
    cpu_wr(8'hC0, 32'h12345678, 4'hF, exp_we);
    jtag_rd(8'hC0);
    jtag_wr(8'hC0, 32'h0BADF00D);
    jtag_rd(8'hC0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = init_word(i);
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_jtag_read();
    test_jtag_write();
    test_byteenable();
    test_contention();
    test_same_cycle();
    test_overrun_reset();
    test_wprot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
